mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-ported 2D memory datapath (R×C cells, N bits each). It accepts read/write requests from two independent requesters over a req/gnt handshake and drives the datapath's req/rw/cs/ar/ac/Qi inputs one transaction at a time. It captures the datapath's registered read result (Qa/valid) and returns it to the requester that issued the read. It sits between the client blocks and the datapath; the top level ties datapath rst to ~rst_n.

---
 rtl/mem_arbiter_if.sv | 42 ++++
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between two requesters, mem_arbiter and the memory datapath.
// Handshake: a request moves on a rising edge where pX_req && pX_gnt. pX_req is held until granted.
// pX_gnt is combinational and only ever asserted while the arbiter is idle.
interface mem_arbiter_if #(
   parameter int R = 4,
   parameter int C = 4,
   parameter int N = 4
);
   localparam int AW_R = $clog2(R);
   localparam int AW_C = $clog2(C);

   logic            p0_req,    p1_req;
   logic            p0_rw,     p1_rw;
   logic [AW_R-1:0] p0_ar,     p1_ar;
   logic [AW_C-1:0] p0_ac,     p1_ac;
   logic [N-1:0]    p0_wdata,  p1_wdata;
   logic            p0_gnt,    p1_gnt;
   logic            p0_rvalid, p1_rvalid;
   logic [N-1:0]    p0_rdata,  p1_rdata;
   logic            p0_err,    p1_err;

   logic            dp_req, dp_rw, dp_cs;
   logic [AW_R-1:0] dp_ar;
   logic [AW_C-1:0] dp_ac;
   logic [N-1:0]    dp_qi;
   logic [N-1:0]    dp_qa;
   logic            dp_valid;

   modport slave (
      input  p0_req, p1_req, p0_rw, p1_rw, p0_ar, p1_ar, p0_ac, p1_ac,
             p0_wdata, p1_wdata, dp_qa, dp_valid,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             p0_err, p1_err, dp_req, dp_rw, dp_cs, dp_ar, dp_ac, dp_qi
   );

   modport master (
      output p0_req, p1_req, p0_rw, p1_rw, p0_ar, p1_ar, p0_ac, p1_ac,
             p0_wdata, p1_wdata, dp_qa, dp_valid,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             p0_err, p1_err, dp_req, dp_rw, dp_cs, dp_ar, dp_ac, dp_qi
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that runs one transaction at a time on a single-ported
// R x C memory datapath and returns each read result to the port that issued it.
module mem_arbiter #(
   parameter int R = 4,
   parameter int C = 4,
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_arbiter_if.slave bus,
   output logic         busy,
   output logic [1:0]   state_dbg
);
   localparam int AW_R = $clog2(R);
   localparam int AW_C = $clog2(C);
   localparam logic [AW_R:0] R_LIM = R[AW_R:0];
   localparam logic [AW_C:0] C_LIM = C[AW_C:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      RD_WAIT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            last_gnt_q, owner_q, oor_q;
   logic            sel, grant, rsp_ok, rsp_err;
   logic            in_rw, in_oor;
   logic [AW_R-1:0] in_ar;
   logic [AW_C-1:0] in_ac;
   logic [N-1:0]    in_wdata;

   // A lone requester always wins; on a tie the port that did not win last time goes.
   always_comb begin
      sel = ~last_gnt_q;
      if (bus.p0_req && !bus.p1_req) begin
         sel = 1'b0;
      end else if (bus.p1_req && !bus.p0_req) begin
         sel = 1'b1;
      end
   end

   assign in_rw    = sel ? bus.p1_rw    : bus.p0_rw;
   assign in_ar    = sel ? bus.p1_ar    : bus.p0_ar;
   assign in_ac    = sel ? bus.p1_ac    : bus.p0_ac;
   assign in_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
   assign in_oor   = ({1'b0, in_ar} >= R_LIM) || ({1'b0, in_ac} >= C_LIM);

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      rsp_ok  = 1'b0;
      rsp_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst_n && (bus.p0_req || bus.p1_req)) begin
               grant   = 1'b1;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            // Out-of-range reads answer straight away; nothing went to the memory.
            if (bus.dp_rw && oor_q) begin
               rsp_err = 1'b1;
               state_d = IDLE;
            end else if (bus.dp_rw) begin
               state_d = RD_WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            if (bus.dp_valid) begin
               rsp_ok  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.p0_gnt = grant & ~sel;
   assign bus.p1_gnt = grant &  sel;
   assign busy       = (state_q != IDLE);
   assign state_dbg  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q    <= 1'b1;
         owner_q       <= 1'b0;
         oor_q         <= 1'b0;
         bus.dp_req    <= 1'b0;
         bus.dp_cs     <= 1'b0;
         bus.dp_rw     <= 1'b0;
         bus.dp_ar     <= '0;
         bus.dp_ac     <= '0;
         bus.dp_qi     <= '0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         bus.p0_rdata  <= '0;
         bus.p1_rdata  <= '0;
         bus.p0_err    <= 1'b0;
         bus.p1_err    <= 1'b0;
      end else begin
         bus.dp_req    <= 1'b0;
         bus.dp_cs     <= 1'b0;
         bus.p0_rvalid <= 1'b0;
         bus.p1_rvalid <= 1'b0;
         if (grant) begin
            bus.dp_rw  <= in_rw;
            bus.dp_ar  <= in_ar;
            bus.dp_ac  <= in_ac;
            bus.dp_qi  <= in_wdata;
            bus.dp_req <= ~in_oor;
            bus.dp_cs  <= ~in_oor;
            oor_q      <= in_oor;
            owner_q    <= sel;
            last_gnt_q <= sel;
         end
         if (rsp_ok || rsp_err) begin
            if (owner_q) begin
               bus.p1_rvalid <= 1'b1;
               bus.p1_rdata  <= rsp_ok ? bus.dp_qa : '0;
               bus.p1_err    <= rsp_err;
            end else begin
               bus.p0_rvalid <= 1'b1;
               bus.p0_rdata  <= rsp_ok ? bus.dp_qa : '0;
               bus.p0_err    <= rsp_err;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a
// transaction-level model (grant schedule, expected responses, shadow memory).
module tb_mem_arbiter;
   localparam int R = 3;
   localparam int C = 3;
   localparam int N = 4;
   localparam int AW_R = $clog2(R);
   localparam int AW_C = $clog2(C);

   typedef struct {
      int          cyc;
      bit          port;
      logic [N-1:0] data;
      bit          err;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic [1:0] state_dbg;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if #(.R(R), .C(C), .N(N)) bus ();

   mem_arbiter #(.R(R), .C(C), .N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   // ---------------- datapath stand-in ----------------
   logic [N-1:0] dmem [0:3][0:3];
   bit dmem_init = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.dp_valid <= 1'b0;
         bus.dp_qa    <= '0;
         if (!dmem_init) begin
            for (int i = 0; i < 4; i++)
               for (int j = 0; j < 4; j++)
                  dmem[i][j] <= '0;
            dmem_init <= 1'b1;
         end
      end else begin
         bus.dp_valid <= bus.dp_req && bus.dp_cs && bus.dp_rw;
         if (bus.dp_req && bus.dp_cs) begin
            if (bus.dp_rw) bus.dp_qa <= dmem[bus.dp_ar][bus.dp_ac];
            else           dmem[bus.dp_ar][bus.dp_ac] <= bus.dp_qi;
         end
      end
   end

   // ---------------- check helper ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   ev_t          exp_q[$];
   logic [N-1:0] mem_m [0:R-1][0:C-1];
   bit           mm_init = 1'b0;
   int           free_at = 0;
   bit           last_m = 1'b1;
   int           iss_cyc = -1;
   bit           iss_ok, iss_rw;
   logic [AW_R-1:0] iss_ar;
   logic [AW_C-1:0] iss_ac;
   logic [N-1:0] iss_qi;
   logic [N-1:0] hold0, hold1;

   always @(negedge clk) begin
      bit busy_e, sel, g0, g1, e0, e1, p, rw, ok;
      logic [AW_R-1:0] ar;
      logic [AW_C-1:0] ac;
      logic [N-1:0] wd;
      ev_t ev;
      if (!rst_n) begin
         if (!mm_init) begin
            for (int i = 0; i < R; i++)
               for (int j = 0; j < C; j++)
                  mem_m[i][j] = '0;
            mm_init = 1'b1;
         end
         chk("rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
         chk("rst_dp_ctl", {bus.dp_req, bus.dp_cs, bus.dp_rw}, 0);
         chk("rst_dp_bus", {bus.dp_ar, bus.dp_ac, bus.dp_qi}, 0);
         chk("rst_resp", {bus.p0_rvalid, bus.p1_rvalid, bus.p0_err, bus.p1_err}, 0);
         chk("rst_rdata", {bus.p0_rdata, bus.p1_rdata}, 0);
         chk("rst_busy", busy, 0);
         free_at = 0;
         last_m  = 1'b1;
         iss_cyc = -1;
         hold0   = '0;
         hold1   = '0;
         exp_q.delete();
      end else begin
         busy_e = (cyc < free_at);
         chk("busy", busy, busy_e);
         g0 = 1'b0;
         g1 = 1'b0;
         if (!busy_e && (bus.p0_req || bus.p1_req)) begin
            sel = (bus.p0_req && bus.p1_req) ? !last_m : bus.p1_req;
            g0  = !sel;
            g1  = sel;
         end
         chk("p0_gnt", bus.p0_gnt, g0);
         chk("p1_gnt", bus.p1_gnt, g1);

         e0 = (cyc == iss_cyc) && iss_ok;
         chk("dp_req", bus.dp_req, e0);
         chk("dp_cs", bus.dp_cs, e0);
         if (e0) begin
            chk("dp_bus", {bus.dp_rw, bus.dp_ar, bus.dp_ac, bus.dp_qi},
                {iss_rw, iss_ar, iss_ac, iss_qi});
            if (!iss_rw) mem_m[iss_ar][iss_ac] = iss_qi;
         end

         e0 = 1'b0;
         e1 = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            ev = exp_q.pop_front();
            if (ev.port) begin
               e1 = 1'b1;
               hold1 = ev.data;
               chk("p1_err", bus.p1_err, ev.err);
            end else begin
               e0 = 1'b1;
               hold0 = ev.data;
               chk("p0_err", bus.p0_err, ev.err);
            end
         end
         chk("p0_rvalid", bus.p0_rvalid, e0);
         chk("p1_rvalid", bus.p1_rvalid, e1);
         chk("p0_rdata", bus.p0_rdata, hold0);
         chk("p1_rdata", bus.p1_rdata, hold1);

         if (g0 || g1) begin
            p  = g1;
            rw = p ? bus.p1_rw : bus.p0_rw;
            ar = p ? bus.p1_ar : bus.p0_ar;
            ac = p ? bus.p1_ac : bus.p0_ac;
            wd = p ? bus.p1_wdata : bus.p0_wdata;
            ok = (int'(ar) < R) && (int'(ac) < C);
            last_m  = p;
            iss_cyc = cyc + 1;
            iss_ok  = ok;
            iss_rw  = rw;
            iss_ar  = ar;
            iss_ac  = ac;
            iss_qi  = wd;
            ev.port = p;
            if (rw && ok) begin
               ev.cyc = cyc + 3; ev.data = mem_m[ar][ac]; ev.err = 1'b0;
               exp_q.push_back(ev);
               free_at = cyc + 3;
            end else if (rw) begin
               ev.cyc = cyc + 2; ev.data = '0; ev.err = 1'b1;
               exp_q.push_back(ev);
               free_at = cyc + 2;
            end else begin
               free_at = cyc + 2;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_port(input bit p, input bit req, input bit rw,
                           input logic [1:0] ar, input logic [1:0] ac, input logic [N-1:0] wd);
      if (p) begin
         bus.p1_req = req; bus.p1_rw = rw; bus.p1_ar = ar; bus.p1_ac = ac; bus.p1_wdata = wd;
      end else begin
         bus.p0_req = req; bus.p0_rw = rw; bus.p0_ar = ar; bus.p0_ac = ac; bus.p0_wdata = wd;
      end
   endtask

   // Raise a request, wait (bounded) for its grant, then drop it after the transfer edge.
   task automatic do_req(input bit p, input bit rw, input logic [1:0] ar, input logic [1:0] ac,
                         input logic [N-1:0] wd, output int gc);
      bit got = 1'b0;
      gc = -1;
      @(posedge clk); #1;
      set_port(p, 1'b1, rw, ar, ac, wd);
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (p ? bus.p1_gnt : bus.p0_gnt) begin
            got = 1'b1;
            gc  = cyc;
         end
      end
      @(posedge clk); #1;
      if (p) bus.p1_req = 1'b0; else bus.p0_req = 1'b0;
      chk("grant_seen", got, 1);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int gc;
      int gq[$];
      int gcs[4];
      logic [1:0] wr_ar[4];
      logic [1:0] wr_ac[4];
      logic [N-1:0] wr_d[4];

      rst_n = 1'b0;
      set_port(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, '0);
      set_port(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0);

      // Reset held with a pending request
      repeat (3) begin
         @(negedge clk);
         chk("lit_rst_gnt", {bus.p0_gnt, bus.p1_gnt}, 0);
         chk("lit_rst_dp", {bus.dp_req, bus.dp_cs}, 0);
         chk("lit_rst_busy", {busy, bus.p0_rvalid, bus.p1_rvalid}, 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("lit_release_p0_gnt", bus.p0_gnt, 1);
      @(posedge clk); #1;
      bus.p0_req = 1'b0;
      repeat (4) @(posedge clk);

      // Write then read on port 0
      do_req(1'b0, 1'b0, 2'd1, 2'd2, 4'hA, gc);
      do_req(1'b0, 1'b1, 2'd1, 2'd2, 4'h0, gc);
      repeat (2) begin
         @(negedge clk);
         chk("lit_rd_p1_quiet", bus.p1_rvalid, 0);
      end
      @(negedge clk);
      chk("lit_rd_p0_rvalid", bus.p0_rvalid, 1);
      chk("lit_rd_p0_rdata", bus.p0_rdata, 4'hA);
      chk("lit_rd_p1_rvalid", bus.p1_rvalid, 0);

      // Contention: both ports reading continuously
      do_req(1'b0, 1'b0, 2'd0, 2'd0, 4'h3, gc);
      do_req(1'b1, 1'b0, 2'd2, 2'd2, 4'h5, gc);
      @(posedge clk); #1;
      set_port(1'b0, 1'b1, 1'b1, 2'd0, 2'd0, '0);
      set_port(1'b1, 1'b1, 1'b1, 2'd2, 2'd2, '0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (bus.p0_gnt) gq.push_back(0);
         if (bus.p1_gnt) gq.push_back(1);
         if (bus.p0_rvalid) chk("lit_cont_p0_rdata", bus.p0_rdata, 4'h3);
         if (bus.p1_rvalid) chk("lit_cont_p1_rdata", bus.p1_rdata, 4'h5);
      end
      @(posedge clk); #1;
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      chk("lit_cont_ngrants", (gq.size() >= 4), 1);
      for (int i = 0; i < 4 && i < gq.size(); i++)
         chk("lit_cont_order", gq[i], i % 2);
      repeat (5) @(posedge clk);

      // Out-of-range accesses
      do_req(1'b1, 1'b1, 2'd3, 2'd0, 4'h0, gc);
      @(negedge clk);
      chk("lit_oor_cs_t1", bus.dp_cs, 0);
      @(negedge clk);
      chk("lit_oor_cs_t2", bus.dp_cs, 0);
      chk("lit_oor_p1_resp", {bus.p1_rvalid, bus.p1_err}, 2'b11);
      chk("lit_oor_p1_rdata", bus.p1_rdata, 0);
      do_req(1'b0, 1'b1, 2'd0, 2'd3, 4'h0, gc);
      repeat (2) @(negedge clk);
      chk("lit_oor_p0_resp", {bus.p0_rvalid, bus.p0_err, bus.p0_rdata}, {2'b11, 4'h0});
      do_req(1'b1, 1'b0, 2'd1, 2'd3, 4'hF, gc);
      do_req(1'b0, 1'b1, 2'd1, 2'd2, 4'h0, gc);
      repeat (3) @(negedge clk);
      chk("lit_oor_wr_dropped", {bus.p0_rvalid, bus.p0_err, bus.p0_rdata}, {2'b10, 4'hA});

      // Reset in the middle of a read
      do_req(1'b0, 1'b1, 2'd2, 2'd2, 4'h0, gc);
      @(posedge clk); #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("lit_midrst_quiet", {bus.p0_rvalid, bus.p1_rvalid, busy}, 0);
      end
      @(posedge clk); #1;
      set_port(1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 4'h1);
      set_port(1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 4'h2);
      @(negedge clk);
      chk("lit_midrst_tie", {bus.p0_gnt, bus.p1_gnt}, 2'b10);
      @(posedge clk); #1;
      bus.p0_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.p1_req = 1'b0;
      repeat (3) @(posedge clk);

      // Back-to-back writes from port 1, then read them back on port 0
      wr_ar = '{2'd0, 2'd1, 2'd2, 2'd0};
      wr_ac = '{2'd1, 2'd1, 2'd0, 2'd2};
      wr_d  = '{4'h6, 4'h7, 4'h8, 4'h9};
      for (int i = 0; i < 4; i++)
         do_req(1'b1, 1'b0, wr_ar[i], wr_ac[i], wr_d[i], gcs[i]);
      for (int i = 1; i < 4; i++)
         chk("lit_b2b_spacing", gcs[i] - gcs[i-1], 2);
      for (int i = 0; i < 4; i++) begin
         do_req(1'b0, 1'b1, wr_ar[i], wr_ac[i], 4'h0, gc);
         repeat (3) @(negedge clk);
         chk("lit_b2b_readback", {bus.p0_rvalid, bus.p0_rdata}, {1'b1, wr_d[i]});
      end

      // Random traffic, including out-of-range addresses and short resets
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         rst_n = ($urandom_range(0, 149) != 0);
         set_port(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
         set_port(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), N'($urandom_range(0, 15)));
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b0;
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
